vortex_apb_ctrl: RTL and testbench

VORTEX_APB_CTRL -- requirements
Module: vortex_apb_ctrl

---
 rtl/vortex_apb_ctrl.sv | 94 +++++++++
 tb/tb_vortex_apb_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vortex_apb_ctrl.sv
// vortex_apb_ctrl: APB control block for the Vortex accelerator (address translation, run FSM, cycle count, irq).
module vortex_apb_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int RESET_DELAY    = 12,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic                      vx_busy,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr_raw,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr_raw,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic                      vx_clk_en,
  output logic                      vx_reset,
  output logic                      irq
);
  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;
  localparam int DW = RESET_DELAY > 1 ? $clog2(RESET_DELAY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(RESET_DELAY - 1);
  state_t               state_q, state_d;
  logic [31:0]          base_q;
  logic                 irq_en_q, done_q, seen_q;
  logic [DW-1:0]        dly_q;
  logic [CNT_WIDTH-1:0] cyc_q;
  logic [7:0]           a;
  logic                 hit_base, hit_ctrl, hit_stat, hit_cyc, hit;
  logic                 wr, start, abort, go, set_done, clr_done;
  logic                 unused_paddr;
  assign a            = paddr[7:0];
  assign unused_paddr = ^paddr[31:8];
  assign hit_base     = a == 8'h50;
  assign hit_ctrl     = a == 8'h54;
  assign hit_stat     = a == 8'h58;
  assign hit_cyc      = a == 8'h5C;
  assign hit          = hit_base | hit_ctrl | hit_stat | hit_cyc;
  assign wr           = psel & penable & pwrite & hit;
  assign abort        = wr & hit_ctrl & pwdata[1];
  assign start        = wr & hit_ctrl & pwdata[0] & ~pwdata[1];
  assign pready       = 1'b1;
  assign pslverr      = psel & penable & ~hit;
  assign araddr       = araddr_raw + AXI_ADDR_WIDTH'(base_q);
  assign awaddr       = awaddr_raw + AXI_ADDR_WIDTH'(base_q);
  assign vx_clk_en    = state_q == S_RST || state_q == S_RUN;
  assign vx_reset     = state_q != S_RUN;
  assign irq          = done_q & irq_en_q;
  always_comb begin
    state_d = state_q;
    if (abort && (state_q == S_RST || state_q == S_RUN)) state_d = S_IDLE;
    else if (start && (state_q == S_IDLE || state_q == S_DONE)) state_d = S_RST;
    else if (state_q == S_RST && dly_q == DLY_LAST) state_d = S_RUN;
    else if (state_q == S_RUN && seen_q && !vx_busy) state_d = S_DONE;
    go       = state_d == S_RST && state_q != S_RST;
    set_done = state_q == S_RUN && state_d == S_DONE;
    clr_done = go | (wr & hit_stat & pwdata[1]);
  end
  always_comb begin
    prdata = '0;
    if (psel && !pwrite)
      prdata = hit_base ? base_q :
               hit_ctrl ? {29'b0, irq_en_q, 2'b0} :
               hit_stat ? {29'b0, state_q == S_RUN, done_q, vx_busy} :
               hit_cyc  ? 32'(cyc_q) : '0;
  end
  // The completion cycle itself is not counted: CYCLES covers cycles that stay in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      seen_q   <= 1'b0;
      dly_q    <= '0;
      cyc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (wr && hit_base) base_q <= pwdata;
      if (wr && hit_ctrl) irq_en_q <= pwdata[2];
      done_q <= set_done | (done_q & ~clr_done);
      seen_q <= state_q == S_RUN && (seen_q || vx_busy);
      dly_q  <= state_q == S_RST ? dly_q + 1'b1 : '0;
      if (go) cyc_q <= '0;
      else if (state_q == S_RUN && state_d == S_RUN && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_vortex_apb_ctrl.sv
// tb_vortex_apb_ctrl: randomized scenario bench; a 32-bit and a 4-bit counter instance share all stimulus.
module tb_vortex_apb_ctrl;
  logic        clk = 0, reset = 1, psel = 0, penable = 0, pwrite = 0, vx_busy = 0;
  logic [31:0] paddr = 0, pwdata = 0, araddr_raw = 0, awaddr_raw = 0;
  logic [31:0] prdata_a, prdata_b, araddr_a, araddr_b, awaddr_a, awaddr_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic        clk_en_a, clk_en_b, vxr_a, vxr_b, irq_a, irq_b;
  logic [31:0] r_a, r_b, m_base;
  logic        rerr, werr;
  int          n_vec = 0, n_bad = 0;

  vortex_apb_ctrl dut_a (.clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
    .vx_busy(vx_busy), .araddr_raw(araddr_raw), .awaddr_raw(awaddr_raw), .araddr(araddr_a),
    .awaddr(awaddr_a), .vx_clk_en(clk_en_a), .vx_reset(vxr_a), .irq(irq_a));
  vortex_apb_ctrl #(.CNT_WIDTH(4)) dut_b (.clk(clk), .reset(reset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .vx_busy(vx_busy), .araddr_raw(araddr_raw), .awaddr_raw(awaddr_raw),
    .araddr(araddr_b), .awaddr(awaddr_b), .vx_clk_en(clk_en_b), .vx_reset(vxr_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    paddr = {24'h0, a}; pwdata = d; pwrite = 1; psel = 1; penable = 0;
    tick();
    penable = 1;
    #1 werr = pslverr_a;
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    paddr = {24'h0, a}; pwrite = 0; psel = 1; penable = 1;
    #1 r_a = prdata_a; r_b = prdata_b; rerr = pslverr_a;
    psel = 0; penable = 0;
    tick();
  endtask

  task automatic wait_run();
    int k = 0;
    while (vxr_a && k < 50) begin tick(); k++; end
    n_vec++;
    if (vxr_a !== 1'b0) begin n_bad++; $display("FAIL wait_run: vx_reset %b want 0 within 50 cycles", vxr_a); end
  endtask

  task automatic test_reset();
    logic [7:0] regs[4] = '{8'h50, 8'h54, 8'h58, 8'h5C};
    reset = 1; tick(); tick(); reset = 0;
    n_vec++;
    if ({clk_en_a, vxr_a, irq_a, pslverr_a, pready_a, prdata_a, clk_en_b, vxr_b, irq_b} !== {5'b01001, 32'h0, 3'b010}) begin
      n_bad++; $display("FAIL reset_outputs: got en=%b rst=%b irq=%b err=%b rdy=%b rd=%h want 0 1 0 0 1 0",
        clk_en_a, vxr_a, irq_a, pslverr_a, pready_a, prdata_a);
    end
    foreach (regs[i]) begin
      rd(regs[i]);
      n_vec++;
      if ({r_a, r_b, rerr} !== 65'h0) begin
        n_bad++; $display("FAIL reset_reg %h: got %h/%h err=%b want 0/0 err=0", regs[i], r_a, r_b, rerr);
      end
    end
  endtask

  task automatic test_base();
    for (int i = 0; i < 5; i++) begin
      m_base     = i == 0 ? 32'h8000_0000 : $urandom;
      araddr_raw = i == 0 ? 32'h9000_0010 : $urandom;
      awaddr_raw = $urandom;
      wr(8'h50, m_base);
      n_vec++;
      if (araddr_a !== araddr_raw + m_base || awaddr_a !== awaddr_raw + m_base || araddr_b !== araddr_raw + m_base) begin
        n_bad++; $display("FAIL translate: got ar=%h aw=%h want ar=%h aw=%h", araddr_a, awaddr_a,
          araddr_raw + m_base, awaddr_raw + m_base);
      end
      if (i == 0) begin
        n_vec++;
        if (araddr_a !== 32'h1000_0010) begin n_bad++; $display("FAIL wrap: got %h want 10000010", araddr_a); end
      end
      rd(8'h50);
      n_vec++;
      if (r_a !== m_base) begin n_bad++; $display("FAIL base_rd: got %h want %h", r_a, m_base); end
    end
  endtask

  task automatic test_run(input int z, input int b, input logic ie);
    int k = 0;
    int exp_c = z + b;
    wr(8'h54, {29'b0, ie, 2'b00});
    wr(8'h54, {29'b0, ie, 2'b01});
    n_vec++;
    if (clk_en_a !== 1'b1) begin n_bad++; $display("FAIL start_clk_en: got %b want 1", clk_en_a); end
    while (clk_en_a && vxr_a && k < 100) begin tick(); k++; end
    n_vec++;
    if (k !== 12 || vxr_a !== 1'b0 || clk_en_a !== 1'b1) begin
      n_bad++; $display("FAIL reset_window: got %0d cycles rst=%b en=%b want 12 cycles rst=0 en=1", k, vxr_a, clk_en_a);
    end
    vx_busy = 0;
    rd(8'h58);
    n_vec++;
    if (r_a !== 32'h4) begin n_bad++; $display("FAIL run_status: got %h want 4", r_a); end
    repeat (z - 1) tick();
    vx_busy = 1;
    repeat (b) tick();
    vx_busy = 0;
    tick();
    n_vec++;
    if ({clk_en_a, vxr_a, irq_a, irq_b} !== {2'b01, ie, ie}) begin
      n_bad++; $display("FAIL done_outputs: got en=%b rst=%b irq=%b want 0 1 %b", clk_en_a, vxr_a, irq_a, ie);
    end
    rd(8'h5C);
    n_vec++;
    if (r_a !== 32'(exp_c) || r_b !== 32'(exp_c > 15 ? 15 : exp_c)) begin
      n_bad++; $display("FAIL cycles z=%0d b=%0d: got %h/%h want %h/%h", z, b, r_a, r_b, exp_c, exp_c > 15 ? 15 : exp_c);
    end
    rd(8'h58);
    n_vec++;
    if (r_a !== 32'h2) begin n_bad++; $display("FAIL done_status: got %h want 2", r_a); end
    if (ie) begin
      wr(8'h58, 32'h2);
      rd(8'h58);
      n_vec++;
      if (irq_a !== 1'b0 || r_a !== 32'h0) begin
        n_bad++; $display("FAIL w1c: got irq=%b status=%h want 0 0", irq_a, r_a);
      end
    end
  endtask

  task automatic test_abort();
    wr(8'h54, 32'h3);
    n_vec++;
    if (clk_en_a !== 1'b0 || vxr_a !== 1'b1) begin n_bad++; $display("FAIL idle_start_abort: got en=%b want 0", clk_en_a); end
    wr(8'h54, 32'h1);
    wr(8'h54, 32'h3);
    repeat (15) tick();
    n_vec++;
    if (clk_en_a !== 1'b0 || vxr_a !== 1'b1) begin
      n_bad++; $display("FAIL abort_in_reset: got en=%b rst=%b want 0 1", clk_en_a, vxr_a);
    end
    wr(8'h54, 32'h1);
    wait_run();
    vx_busy = 1;
    repeat (3) tick();
    wr(8'h54, 32'h1);
    rd(8'h5C);
    n_vec++;
    if (r_a !== 32'd5 || vxr_a !== 1'b0) begin
      n_bad++; $display("FAIL start_ignored_in_run: got cycles=%h rst=%b want 5 0", r_a, vxr_a);
    end
    wr(8'h54, 32'h3);
    rd(8'h58);
    n_vec++;
    if (clk_en_a !== 1'b0 || vxr_a !== 1'b1 || r_a !== 32'h1) begin
      n_bad++; $display("FAIL abort_in_run: got en=%b rst=%b status=%h want 0 1 1", clk_en_a, vxr_a, r_a);
    end
    vx_busy = 0;
  endtask

  task automatic test_err();
    logic [7:0] a;
    for (int i = 0; i < 5; i++) begin
      a = i == 0 ? 8'h64 : 8'($urandom);
      if (a inside {8'h50, 8'h54, 8'h58, 8'h5C}) a = 8'h64;
      wr(a, $urandom);
      rd(a);
      n_vec++;
      if (werr !== 1'b1 || rerr !== 1'b1 || r_a !== 32'h0) begin
        n_bad++; $display("FAIL bad_addr %h: got werr=%b rerr=%b rd=%h want 1 1 0", a, werr, rerr, r_a);
      end
    end
    rd(8'h50);
    n_vec++;
    if (r_a !== m_base || rerr !== 1'b0) begin n_bad++; $display("FAIL err_no_change: got %h want %h", r_a, m_base); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] regs[4] = '{8'h50, 8'h54, 8'h58, 8'h5C};
    wr(8'h50, 32'h1234_5678);
    wr(8'h54, 32'h5);
    wait_run();
    vx_busy = 1;
    repeat (4) tick();
    reset = 1;
    tick();
    n_vec++;
    if ({clk_en_a, vxr_a, irq_a, clk_en_b, vxr_b} !== 5'b01001 || araddr_a !== araddr_raw) begin
      n_bad++; $display("FAIL mid_run_reset: got en=%b rst=%b irq=%b ar=%h want 0 1 0 %h",
        clk_en_a, vxr_a, irq_a, araddr_a, araddr_raw);
    end
    reset = 0; vx_busy = 0;
    foreach (regs[i]) begin
      rd(regs[i]);
      n_vec++;
      if ({r_a, r_b} !== 64'h0) begin n_bad++; $display("FAIL mid_reset_reg %h: got %h/%h want 0", regs[i], r_a, r_b); end
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_run(3, 5, 1'b1);
    test_run(2, 20, 1'b0);
    for (int i = 0; i < 4; i++) test_run($urandom_range(6, 1), $urandom_range(25, 1), 1'($urandom));
    test_abort();
    test_err();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
